// File: rtl/coord_compute_pipe_if.sv
// Bundles the group handshake, operand data and result bus of coord_compute_pipe.
//   master : producer/consumer side (drives group inputs and out_ready)
//   slave  : the coordinate pipe itself
// Signals: in_valid/in_ready, tile_start, bitwidth, weight/activation_indices,
//          weight/activation_dim, out_rows/out_cols, out_valid/out_ready,
//          row_coord/col_coord, coord_valid, err.
interface coord_compute_pipe_if #(
  parameter int N_LANES = 16,
  parameter int IDX_W   = 4,
  parameter int DIM_W   = 9,
  parameter int COORD_W = 16
);
  logic                                     in_valid;
  logic                                     in_ready;
  logic                                     tile_start;
  logic [1:0]                               bitwidth;
  logic [N_LANES-1:0][IDX_W-1:0]            weight_indices;
  logic [N_LANES-1:0][IDX_W-1:0]            activation_indices;
  logic [DIM_W-1:0]                         weight_dim;
  logic [DIM_W-1:0]                         activation_dim;
  logic [COORD_W-1:0]                       out_rows;
  logic [COORD_W-1:0]                       out_cols;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [N_LANES*N_LANES-1:0][COORD_W-1:0]  row_coord;
  logic [N_LANES*N_LANES-1:0][COORD_W-1:0]  col_coord;
  logic [N_LANES*N_LANES-1:0]               coord_valid;
  logic                                     err;

  modport master (
    output in_valid, tile_start, bitwidth, weight_indices, activation_indices,
           weight_dim, activation_dim, out_rows, out_cols, out_ready,
    input  in_ready, out_valid, row_coord, col_coord, coord_valid, err
  );

  modport slave (
    input  in_valid, tile_start, bitwidth, weight_indices, activation_indices,
           weight_dim, activation_dim, out_rows, out_cols, out_ready,
    output in_ready, out_valid, row_coord, col_coord, coord_valid, err
  );
endinterface

// File: rtl/coord_compute_pipe.sv
// Sparse-convolution coordinate pipe. Accepts one group of zero-run compressed
// weight/activation indices, decodes one lane per cycle into absolute indices
// and (row, col) positions, then emits the output-plane coordinate of every
// weight x activation product together with an in-bounds flag.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : coord_compute_pipe_if slave (group in, coordinates out, err)
module coord_compute_pipe #(
  parameter int N_LANES = 16,
  parameter int IDX_W   = 4,
  parameter int DIM_W   = 9,
  parameter int ACC_W   = 16,
  parameter int COORD_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  coord_compute_pipe_if.slave  bus
);
  localparam int NE = N_LANES * N_LANES;
  localparam int KW = $clog2(N_LANES);
  localparam logic [KW:0] L_FULL = (KW+1)'(N_LANES);
  localparam logic [KW:0] L_HALF = (KW+1)'(N_LANES / 2);
  localparam logic [KW:0] L_QTR  = (KW+1)'(N_LANES / 4);

  typedef enum logic [1:0] {IDLE, DECODE, EMIT} state_t;

  state_t                        state_q;
  logic [1:0]                    bw_q;
  logic [N_LANES-1:0][IDX_W-1:0] widx_q, aidx_q;
  logic [DIM_W-1:0]              wdim_q, adim_q;
  logic [COORD_W-1:0]            orows_q, ocols_q;
  logic [KW:0]                   k_q;
  logic [ACC_W-1:0]              wstart_q, astart_q;
  // Absolute index of the previous lane; holds the group start before lane 0.
  logic [ACC_W-1:0]              wprev_q, aprev_q;
  logic [ACC_W-1:0]              wrow_q [N_LANES];
  logic [ACC_W-1:0]              wcol_q [N_LANES];
  logic [ACC_W-1:0]              arow_q [N_LANES];
  logic [ACC_W-1:0]              acol_q [N_LANES];
  logic [NE-1:0][COORD_W-1:0]    row_q, col_q, row_d, col_d;
  logic [NE-1:0]                 cvalid_q, cvalid_d;
  logic                          out_valid_q, err_q;

  logic [KW:0]                   lanes;
  logic [KW-1:0]                 lane;
  logic [ACC_W-1:0]              wabs_d, aabs_d;
  logic [ACC_W-1:0]              wquo, wrem, aquo, arem;

  always_comb begin
    case (bw_q)
      2'b01:   lanes = L_HALF;
      2'b10:   lanes = L_QTR;
      default: lanes = L_FULL;
    endcase
    lane = k_q[KW-1:0];
    // Lane 0 adds the delta to the start; later lanes skip past the previous nonzero.
    if (k_q == '0) begin
      wabs_d = wprev_q + ACC_W'(widx_q[lane]);
      aabs_d = aprev_q + ACC_W'(aidx_q[lane]);
    end else begin
      wabs_d = wprev_q + ACC_W'(widx_q[lane]) + ACC_W'(1);
      aabs_d = aprev_q + ACC_W'(aidx_q[lane]) + ACC_W'(1);
    end
    wquo = wabs_d / ACC_W'(wdim_q);
    wrem = wabs_d % ACC_W'(wdim_q);
    aquo = aabs_d / ACC_W'(adim_q);
    arem = aabs_d % ACC_W'(adim_q);
  end

  // Entry e maps to (i, j) = (e / L, e % L); the mapping is fixed per mode,
  // so each entry just muxes between three constant lane pairs.
  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_entry
      localparam int H  = N_LANES / 2;
      localparam int Q  = N_LANES / 4;
      localparam bit A1 = (gi < H * H);
      localparam bit A2 = (gi < Q * Q);
      localparam int I0 = gi / N_LANES;
      localparam int J0 = gi % N_LANES;
      localparam int I1 = A1 ? gi / H : 0;
      localparam int J1 = gi % H;
      localparam int I2 = A2 ? gi / Q : 0;
      localparam int J2 = gi % Q;

      logic [ACC_W-1:0]   wr, wc, ar, ac;
      logic               act;
      logic [COORD_W-1:0] half, r, c;

      always_comb begin
        wr = wrow_q[I0]; wc = wcol_q[I0]; ar = arow_q[J0]; ac = acol_q[J0]; act = 1'b1;
        case (bw_q)
          2'b01: begin
            wr = wrow_q[I1]; wc = wcol_q[I1]; ar = arow_q[J1]; ac = acol_q[J1]; act = A1;
          end
          2'b10: begin
            wr = wrow_q[I2]; wc = wcol_q[I2]; ar = arow_q[J2]; ac = acol_q[J2]; act = A2;
          end
          default: ;
        endcase
      end

      assign half = COORD_W'(wdim_q >> 1);
      assign r    = half - COORD_W'(wr) + COORD_W'(ar) + COORD_W'(1);
      assign c    = half - COORD_W'(wc) + COORD_W'(ac) + COORD_W'(1);

      assign row_d[gi]    = act ? r : '0;
      assign col_d[gi]    = act ? c : '0;
      assign cvalid_d[gi] = act && !r[COORD_W-1] && ($signed(r) < $signed(orows_q))
                                && !c[COORD_W-1] && ($signed(c) < $signed(ocols_q));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bw_q        <= '0;
      widx_q      <= '0;
      aidx_q      <= '0;
      wdim_q      <= '0;
      adim_q      <= '0;
      orows_q     <= '0;
      ocols_q     <= '0;
      k_q         <= '0;
      wstart_q    <= '0;
      astart_q    <= '0;
      wprev_q     <= '0;
      aprev_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cvalid_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        wrow_q[k] <= '0;
        wcol_q[k] <= '0;
        arow_q[k] <= '0;
        acol_q[k] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.bitwidth == 2'b11 || bus.weight_dim == '0 || bus.activation_dim == '0) begin
              err_q <= 1'b1;
            end else begin
              bw_q    <= bus.bitwidth;
              widx_q  <= bus.weight_indices;
              aidx_q  <= bus.activation_indices;
              wdim_q  <= bus.weight_dim;
              adim_q  <= bus.activation_dim;
              orows_q <= bus.out_rows;
              ocols_q <= bus.out_cols;
              wprev_q <= bus.tile_start ? '0 : wstart_q;
              aprev_q <= bus.tile_start ? '0 : astart_q;
              k_q     <= '0;
              state_q <= DECODE;
            end
          end
        end
        DECODE: begin
          if (k_q == lanes) begin
            // Final DECODE cycle: every lane is decoded, publish all entries at once.
            row_q       <= row_d;
            col_q       <= col_d;
            cvalid_q    <= cvalid_d;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            wprev_q      <= wabs_d;
            aprev_q      <= aabs_d;
            wrow_q[lane] <= wquo;
            wcol_q[lane] <= wrem;
            arow_q[lane] <= aquo;
            acol_q[lane] <= arem;
            if (k_q == lanes - 1'b1) begin
              wstart_q <= wabs_d + ACC_W'(1);
              astart_q <= aabs_d + ACC_W'(1);
            end
            k_q <= k_q + 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.row_coord   = row_q;
  assign bus.col_coord   = col_q;
  assign bus.coord_valid = cvalid_q;
  assign bus.err         = err_q;
endmodule
